// File: rtl/normalizer_32.sv
// Sequential leading-zero normalizer: binary search, one stage per clock.
// Optional NORMALIZER_SIGNED_EN counts redundant sign bits instead of zeros.
module normalizer_32 #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic [SHIFT_WIDTH-1:0] o_shift,
  output logic                   o_zero,
  output logic                   o_valid,
  input  logic                   i_ready
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } state_t;

  localparam logic [DATA_WIDTH-1:0] ONES = '1;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  work;
  logic [SHIFT_WIDTH-1:0] count;
  logic [SHIFT_WIDTH-1:0] k;

  logic [SHIFT_WIDTH:0]   stride;
  logic [DATA_WIDTH-1:0]  top_mask;
  logic                   hit;
  logic [DATA_WIDTH-1:0]  work_nxt;
  logic [SHIFT_WIDTH-1:0] count_nxt;

  always_comb begin
    stride = (SHIFT_WIDTH+1)'(1) << k;
`ifdef NORMALIZER_SIGNED_EN
    // window is one bit wider: the sign bit must survive the shift
    top_mask = ~(ONES >> (stride + (SHIFT_WIDTH+1)'(1)));
    hit = ((work & top_mask) == '0) ||
          ((work & top_mask) == top_mask);
`else
    top_mask = ~(ONES >> stride);
    hit = ((work & top_mask) == '0);
`endif
    work_nxt  = work;
    count_nxt = count;
    if (hit) begin
      work_nxt  = work << stride;
      count_nxt = count | (SHIFT_WIDTH'(1) << k);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      work    <= '0;
      count   <= '0;
      k       <= '0;
      o_ready <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_shift <= '0;
      o_zero  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_valid && o_ready) begin
            work    <= i_data;
            count   <= '0;
            k       <= SHIFT_WIDTH'(SHIFT_WIDTH-1);
            o_ready <= 1'b0;
            state   <= SCAN;
          end else begin
            o_ready <= 1'b1;
          end
        end
        SCAN: begin
          work  <= work_nxt;
          count <= count_nxt;
          if (k == '0) begin
            o_data  <= work_nxt;
            o_shift <= count_nxt;
            o_zero  <= (work_nxt == '0);
            o_valid <= 1'b1;
            state   <= HOLD;
          end else begin
            k <= k - SHIFT_WIDTH'(1);
          end
        end
        HOLD: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_normalizer_32.sv
// Self-checking bench for normalizer_32: directed cases plus random words
// compared against a bit-counting reference model.
module tb_normalizer_32;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_data = '0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] o_data;
  logic [4:0]  o_shift;
  logic        o_zero;
  logic        o_valid;
  logic        i_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  normalizer_32 dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_data (i_data),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_data (o_data),
    .o_shift(o_shift),
    .o_zero (o_zero),
    .o_valid(o_valid),
    .i_ready(i_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // count leading bits directly instead of searching
  function automatic void model(input logic [31:0] d,
                                output logic [31:0] od,
                                output logic [31:0] os,
                                output logic [31:0] oz);
    int n = 0;
`ifdef NORMALIZER_SIGNED_EN
    while (n < 31 && d[30-n] == d[31]) n++;
`else
    while (n < 31 && d[31-n] == 1'b0) n++;
`endif
    od = d << n;
    os = n;
    oz = (od == 0) ? 1 : 0;
  endfunction

  task automatic xact(input logic [31:0] d, input int hold,
                      input bit poke);
    logic [31:0] ed, es, ez;
    int lat;
    model(d, ed, es, ez);
    lat = 0;
    while (!o_ready && lat < 20) begin
      @(negedge i_clk);
      lat++;
    end
    chk("ready_wait", 32'(o_ready), 1);
    i_data  = d;
    i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    i_data  = $urandom;
    chk("ready_drop", 32'(o_ready), 0);
    lat = 0;
    while (!o_valid && lat < 20) begin
      @(negedge i_clk);
      lat++;
    end
    chk("latency", lat, 5);
    chk("data", o_data, ed);
    chk("shift", 32'(o_shift), es);
    chk("zero", 32'(o_zero), ez);
    for (int i = 0; i < hold; i++) begin
      i_valid = poke;
      @(negedge i_clk);
      chk("hold_data", o_data, ed);
      chk("hold_shift", 32'(o_shift), es);
      chk("hold_ready", 32'(o_ready), 0);
      chk("hold_valid", 32'(o_valid), 1);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    chk("release_valid", 32'(o_valid), 0);
    chk("release_ready", 32'(o_ready), 1);
    chk("idle_keep", o_data, ed);
  endtask

  task automatic chk_reset_outs();
    chk("rst_ready", 32'(o_ready), 0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_data", o_data, 0);
    chk("rst_shift", 32'(o_shift), 0);
    chk("rst_zero", 32'(o_zero), 0);
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    chk_reset_outs();
    i_rst = 1'b0;
    #1 chk("ready_pre_edge", 32'(o_ready), 0);
    @(negedge i_clk);
    chk("ready_after_rst", 32'(o_ready), 1);

    xact(32'h0000_0001, 0, 1'b0);
    xact(32'h8000_0000, 1, 1'b0);
    xact(32'h0000_0000, 0, 1'b0);
    xact(32'hFFFF_FFFF, 0, 1'b0);
    xact(32'hFFFF_8000, 2, 1'b0);
    xact(32'h0001_2345, 10, 1'b1);

    // reset while stage k=2 is pending
    i_data  = 32'h1234_5678;
    i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    #1 chk_reset_outs();
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("mid_rst_ready0", 32'(o_ready), 0);
    @(negedge i_clk);
    chk("mid_rst_ready1", 32'(o_ready), 1);
    chk("mid_rst_valid", 32'(o_valid), 0);
    xact(32'h00F0_0000, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] r;
      r = $urandom;
      r = r >> $urandom_range(0, 31);
      if (i % 3 == 1) r = ~r;
      xact(r, int'($urandom_range(0, 3)), 1'(i % 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/normalizer_32.md
Name: normalizer_32

Overview:
- Sequential leading-zero normalizer: the inverse of the left/arithmetic barrel shifters in the sin/cos generator.
- Instead of taking a shift amount, it finds one.
- Takes a DATA_WIDTH word and returns the word shifted left until the MSB is significant, plus the shift count.
- Binary search, one stage per clock, valid/ready handshake on both sides.
- Used ahead of the CORDIC/scaling path to normalize amplitudes and phase residues.

Parameters:
- DATA_WIDTH, 32: word width; power of two, minimum 4.
- SHIFT_WIDTH, 5: width of shift count; equals log2(DATA_WIDTH), with 5 for the default.

Ports:
- i_clk, input, 1: clock, rising edge.
- i_rst, input, 1: asynchronous active-high reset.
- i_data, input, DATA_WIDTH: word to normalize.
- i_valid, input, 1: i_data valid.
- o_ready, output, 1: block can accept i_data.
- o_data, output, DATA_WIDTH: normalized word.
- o_shift, output, SHIFT_WIDTH: applied left-shift count.
- o_zero, output, 1: accepted word was all zeros.
- o_valid, output, 1: o_data/o_shift/o_zero valid.
- i_ready, input, 1: downstream accepts result.

Behaviour:
- Reset (async, i_rst=1): state IDLE; o_ready=0; o_valid=0; o_data=0; o_shift=0; o_zero=0; work and count registers 0.
- o_ready is registered. It rises on the first clock edge after i_rst deasserts.
- FSM states: IDLE, SCAN, HOLD.
- IDLE:
  - o_ready=1, o_valid=0.
  - On an edge with i_valid & o_ready: latch i_data into work, clear count, set stage index k=SHIFT_WIDTH-1, set o_ready=0, go to SCAN.
- SCAN: one stage per edge, k from SHIFT_WIDTH-1 down to 0.
  - If work[DATA_WIDTH-1 -: 2^k] is all zero: work <= work << 2^k (zero fill) and count[k] <= 1.
  - Otherwise work and count[k] are unchanged.
  - After stage k=0, go to HOLD with o_valid=1.
  - o_data=work, o_shift=count, o_zero=(work==0).
- Latency: o_valid rises exactly SHIFT_WIDTH edges after the accept edge (5 for the default).
- HOLD:
  - o_valid=1; outputs held stable while i_ready=0.
  - On an edge with o_valid & i_ready: o_valid=0, o_ready=1, go to IDLE.
- Throughput: one word per SHIFT_WIDTH+2 cycles minimum. No overlap: o_ready=0 throughout SCAN and HOLD, and i_valid is ignored there.
- o_data, o_shift and o_zero change only on the SCAN→HOLD transition. They keep their values in IDLE.
- Boundary cases:
  - MSB of input already 1: o_shift=0, o_data=i_data.
  - Input 0: every stage shifts, so o_shift=DATA_WIDTH-1 (31), o_data=0, o_zero=1.
  - i_valid held high continuously: exactly one word is accepted per IDLE visit.
- Reset mid-SCAN or mid-HOLD: transaction discarded, all outputs return to reset values immediately (async). No partial result is ever presented.
- Width rules: shifts are logical within DATA_WIDTH; bits shifted out are discarded. count never exceeds DATA_WIDTH-1.

Optional Feature:
- Macro: NORMALIZER_SIGNED_EN.
- Defined: two's-complement mode, counting redundant sign bits.
  - Stage k test: work[DATA_WIDTH-1 -: 2^k+1] all bits equal.
  - If true: work <<= 2^k, count[k]=1.
  - Result has o_data[DATA_WIDTH-1] != o_data[DATA_WIDTH-2], except for inputs 0 and all-ones.
  - Input 0: o_shift=31, o_data=0, o_zero=1.
  - Input 0xFFFF_FFFF: o_shift=31, o_data=0x8000_0000, o_zero=0.
- Undefined: unsigned leading-zero behaviour as above, with no sign-compare logic synthesized.

Test Plan:
- Basic shift: i_data=0x0000_0001 accepted → o_valid exactly 5 cycles after accept, o_shift=31, o_data=0x8000_0000, o_zero=0.
- Already normalized: i_data=0x8000_0000 → o_shift=0, o_data=0x8000_0000.
- Zero input: i_data=0x0000_0000 → o_shift=31, o_data=0, o_zero=1.
- Backpressure:
  - i_data=0x0001_2345 with i_ready low for 10 cycles in HOLD → o_shift=15, o_data=0x91A2_8000 held stable, o_ready=0.
  - A second i_valid during HOLD is ignored.
  - After i_ready pulse, o_ready=1 next cycle.
- Reset mid-operation: i_rst pulsed during SCAN stage 2 → outputs 0 immediately, o_ready=1 one edge after release, then 0x00F0_0000 → o_shift=8, o_data=0xF000_0000.
- Signed mode (NORMALIZER_SIGNED_EN):
  - 0x0000_0001 → o_shift=30, o_data=0x4000_0000.
  - 0xFFFF_FFFF → o_shift=31, o_data=0x8000_0000.
  - 0xFFFF_8000 → o_shift=16, o_data=0x8000_0000.
